packet_builder: RTL and testbench
=================================

PACKET_BUILDER -- requirements
Module: packet_builder

Interface
REQ-001 Parameter: LEN_W, 16, width of oLength (used only when PACKET_BUILDER_LEN_EN is defined).
REQ-002 iClk  input  1  sole clock; all state changes on the rising edge.
REQ-003 iReset  input  1  asynchronous, active-low reset.
REQ-004 iHeader_A  input  48  header A, packet bytes 0-5; byte 0 in bits [7:0].
REQ-005 iHeader_B  input  32  header B, packet bytes 6-9.
REQ-006 iHeader_C  input  16  header C, packet bytes 10-11.
REQ-007 iHeader_valid  input  1  all three headers valid together.
REQ-008 oHeader_ready  output  1  headers accepted when iHeader_valid and oHeader_ready are both high.
REQ-009 iPayload  input  64  payload beat; beat byte 0 in bits [7:0].
REQ-010 iPayload_valid  input  1  payload beat valid.
REQ-011 iPayload_eop  input  1  last payload beat.
REQ-012 iPayload_byte_enable  input  8  valid bytes; all ones except on the eop beat, where it is contiguous from bit 0 and nonzero.
REQ-013 oPayload_ready  output  1  beat accepted when iPayload_valid and oPayload_ready are both high.
REQ-014 oPacket  output  64  packet beat, same byte order as the packet interface.
REQ-015 oValid, oSop, oEop  output  1 each  packet-interface beat qualifiers.
REQ-016 oByte_enable  output  8  valid bytes of oPacket.
REQ-017 iReady  input  1  downstream accepts the beat when oValid and iReady are both high.
REQ-018 oLength  output  LEN_W  total packet bytes; present only with PACKET_BUILDER_LEN_EN.

Function
REQ-019 Packet byte layout: header A in bytes 0-5, header B in bytes 6-9, header C in bytes 10-11, payload from byte 12 onward; payload is at least 1 byte.
REQ-020 States: IDLE, HDR, MERGE, FLUSH.
REQ-021 Output register "free" condition: !oValid || iReady.
REQ-022 IDLE: oHeader_ready = free; on header accept, load oPacket = header bytes 0-7, oByte_enable=0xFF, oSop=1, oValid=1; keep header bytes 8-11 as a 4-byte residual; go to MERGE.
REQ-023 MERGE: oPayload_ready = free; on beat accept, oPacket = {beat bytes 0-3, residual}; residual = beat bytes 4-7; oSop=0.
REQ-024 MERGE eop beat with n valid bytes, n<=4: emit 4+n bytes, oByte_enable low 4+n bits set, oEop=1; go to IDLE.
REQ-025 MERGE eop beat with n>4: emit 8 bytes, oEop=0; go to FLUSH.
REQ-026 FLUSH: when free, emit residual (n-4 bytes), oByte_enable low n-4 bits set, oEop=1; go to IDLE.
REQ-027 Latency: first beat (oSop) is valid the cycle after header accept; each output beat appears the cycle after its enabling accept.
REQ-028 Backpressure: while oValid && !iReady, oPacket, oSop, oEop, oByte_enable hold stable and both ready outputs are 0.
REQ-029 When free and no new beat is produced, oValid clears to 0 on the next edge.
REQ-030 oHeader_ready and oPayload_ready are never high in the same cycle; headers for the next packet are accepted in the same cycle that the final beat of the current packet is taken by iReady.
REQ-031 Byte-enable bits in unused positions of a beat are 0; the data in disabled bytes is don't-care.

Reset
REQ-032 While iReset=0: state=IDLE; oValid, oSop, oEop=0; oByte_enable=0; oPacket=0; residual=0; oLength=0; oPayload_ready=0.
REQ-033 Reset asserted mid-packet abandons the packet; after release the first beat is an oSop beat for a newly accepted header.

Configuration
REQ-034 With PACKET_BUILDER_LEN_EN defined: oLength accumulates 12 plus the payload bytes and is valid on the oEop beat; it wraps modulo 2^LEN_W.
REQ-035 Without PACKET_BUILDER_LEN_EN: the oLength port and its counter do not exist; all other behaviour is identical.

Verification
REQ-036 3-byte payload, iReady=1 -> 2 beats: be 0xFF with sop, then be 0x7F with eop; beat1 bytes 4-6 = payload.
REQ-037 Single 8-byte payload beat -> 3 beats: be 0xFF, 0xFF, 0x0F; FLUSH beat carries payload bytes 4-7; oLength=20.
REQ-038 25-byte random payload (4 beats, eop be 0x01) -> 5 beats, last be 0x1F with eop; reassembled bytes match headers plus payload.
REQ-039 iReady low for 3 cycles on the 2nd beat -> the beat holds stable, both ready outputs stay 0, and no byte is lost or duplicated.
REQ-040 Back-to-back packets with iHeader_valid held high -> the second oSop beat immediately follows the first oEop beat, with no idle cycle.
REQ-041 iReset pulsed low during MERGE -> all outputs are 0 asynchronously; the next packet is emitted correctly after release.

Source files
------------

// File: rtl/packet_builder.sv
// Builds 64-bit packet beats from a 12-byte header (A/B/C) followed by a 64-bit payload stream.
// Define PACKET_BUILDER_LEN_EN to add the oLength total-byte counter output.
module packet_builder
`ifdef PACKET_BUILDER_LEN_EN
#(
    parameter int LEN_W = 16
)
`endif
(
    input  logic        iClk,
    input  logic        iReset,
    input  logic [47:0] iHeader_A,
    input  logic [31:0] iHeader_B,
    input  logic [15:0] iHeader_C,
    input  logic        iHeader_valid,
    output logic        oHeader_ready,
    input  logic [63:0] iPayload,
    input  logic        iPayload_valid,
    input  logic        iPayload_eop,
    input  logic [7:0]  iPayload_byte_enable,
    output logic        oPayload_ready,
    output logic [63:0] oPacket,
    output logic        oValid,
    output logic        oSop,
    output logic        oEop,
    output logic [7:0]  oByte_enable,
`ifdef PACKET_BUILDER_LEN_EN
    output logic [LEN_W-1:0] oLength,
`endif
    input  logic        iReady
);

    typedef enum logic [1:0] {IDLE, HDR, MERGE, FLUSH} state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] residual;
    logic [3:0]  flush_bytes;
    logic [3:0]  beat_bytes;
    logic        free;
    logic        hdr_accept;
    logic        beat_accept;

    function automatic logic [3:0] count_bytes(input logic [7:0] be);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, be[i]};
        end
        return n;
    endfunction

    function automatic logic [7:0] low_mask(input logic [3:0] n);
        logic [8:0] m;
        m = (9'd1 << n) - 9'd1;
        return m[7:0];
    endfunction

    assign free        = !oValid || iReady;
    assign beat_bytes  = count_bytes(iPayload_byte_enable);
    assign hdr_accept  = iHeader_valid && oHeader_ready;
    assign beat_accept = iPayload_valid && oPayload_ready;

    always_ff @(posedge iClk or negedge iReset) begin
        if (!iReset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Readies are gated by reset so every output reads 0 while reset is held.
    always_comb begin
        state_next     = state;
        oHeader_ready  = 1'b0;
        oPayload_ready = 1'b0;
        case (state)
            IDLE: begin
                oHeader_ready = free && iReset;
                if (iHeader_valid && free && iReset) begin
                    state_next = MERGE;
                end
            end
            MERGE: begin
                oPayload_ready = free && iReset;
                if (iPayload_valid && free && iReset && iPayload_eop) begin
                    state_next = (beat_bytes > 4'd4) ? FLUSH : IDLE;
                end
            end
            FLUSH: begin
                if (free) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge iClk or negedge iReset) begin
        if (!iReset) begin
            oPacket      <= '0;
            oValid       <= 1'b0;
            oSop         <= 1'b0;
            oEop         <= 1'b0;
            oByte_enable <= '0;
            residual     <= '0;
            flush_bytes  <= '0;
        end else if (hdr_accept) begin
            oPacket      <= {iHeader_B[15:0], iHeader_A};
            residual     <= {iHeader_C, iHeader_B[31:16]};
            oByte_enable <= 8'hFF;
            oSop         <= 1'b1;
            oEop         <= 1'b0;
            oValid       <= 1'b1;
        end else if (beat_accept) begin
            // Four residual bytes lead; the beat's upper half becomes the new residual.
            oPacket  <= {iPayload[31:0], residual};
            residual <= iPayload[63:32];
            oSop     <= 1'b0;
            oValid   <= 1'b1;
            if (iPayload_eop && beat_bytes <= 4'd4) begin
                oByte_enable <= low_mask(beat_bytes + 4'd4);
                oEop         <= 1'b1;
            end else begin
                oByte_enable <= 8'hFF;
                oEop         <= 1'b0;
            end
            if (iPayload_eop && beat_bytes > 4'd4) begin
                flush_bytes <= beat_bytes - 4'd4;
            end
        end else if (state == FLUSH && free) begin
            oPacket      <= {32'h0, residual};
            oByte_enable <= low_mask(flush_bytes);
            oSop         <= 1'b0;
            oEop         <= 1'b1;
            oValid       <= 1'b1;
        end else if (free) begin
            oValid <= 1'b0;
        end
    end

`ifdef PACKET_BUILDER_LEN_EN
    always_ff @(posedge iClk or negedge iReset) begin
        if (!iReset) begin
            oLength <= '0;
        end else if (hdr_accept) begin
            oLength <= LEN_W'(12);
        end else if (beat_accept) begin
            oLength <= oLength + LEN_W'(beat_bytes);
        end
    end
`endif

endmodule

// File: tb/tb_packet_builder.sv
// Randomized bench for packet_builder: a byte-stream reference model predicts every output beat.
module tb_packet_builder;

    logic        iClk = 1'b0;
    logic        iReset;
    logic [47:0] iHeader_A;
    logic [31:0] iHeader_B;
    logic [15:0] iHeader_C;
    logic        iHeader_valid;
    logic        oHeader_ready;
    logic [63:0] iPayload;
    logic        iPayload_valid;
    logic        iPayload_eop;
    logic [7:0]  iPayload_byte_enable;
    logic        oPayload_ready;
    logic [63:0] oPacket;
    logic        oValid;
    logic        oSop;
    logic        oEop;
    logic [7:0]  oByte_enable;
`ifdef PACKET_BUILDER_LEN_EN
    logic [15:0] oLength;
`endif
    logic        iReady = 1'b0;

    packet_builder dut (
        .iClk                 (iClk),
        .iReset               (iReset),
        .iHeader_A            (iHeader_A),
        .iHeader_B            (iHeader_B),
        .iHeader_C            (iHeader_C),
        .iHeader_valid        (iHeader_valid),
        .oHeader_ready        (oHeader_ready),
        .iPayload             (iPayload),
        .iPayload_valid       (iPayload_valid),
        .iPayload_eop         (iPayload_eop),
        .iPayload_byte_enable (iPayload_byte_enable),
        .oPayload_ready       (oPayload_ready),
        .oPacket              (oPacket),
        .oValid               (oValid),
        .oSop                 (oSop),
        .oEop                 (oEop),
        .oByte_enable         (oByte_enable),
`ifdef PACKET_BUILDER_LEN_EN
        .oLength              (oLength),
`endif
        .iReady               (iReady)
    );

    always #5 iClk = ~iClk;

    typedef struct {
        logic [63:0] data;
        logic [7:0]  be;
        logic        sop;
        logic        eop;
        int          len;
    } beat_t;

    beat_t       exp_q[$];
    logic [7:0]  pay_q[$];
    int          n_checks = 0;
    int          n_fail = 0;
    int          beats_seen = 0;
    int          cyc = 0;
    int          eop_cyc = 0;
    int          last_gap = 0;
    int          rdy_mode = 0;
    int          base;
    int          to;
    bit          abort = 1'b0;
    bit          hold_prev = 1'b0;
    logic [63:0] snap_data;
    logic [7:0]  snap_be;
    logic        snap_sop;
    logic        snap_eop;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: lay out header + payload as one byte stream and cut it into 8-byte beats.
    task automatic model_packet(input logic [47:0] a, input logic [31:0] b, input logic [15:0] c);
        logic [7:0] bytes[$];
        beat_t      bt;
        int         total;
        int         nbeats;
        for (int i = 0; i < 6; i++) bytes.push_back(a[8*i +: 8]);
        for (int i = 0; i < 4; i++) bytes.push_back(b[8*i +: 8]);
        for (int i = 0; i < 2; i++) bytes.push_back(c[8*i +: 8]);
        foreach (pay_q[i]) bytes.push_back(pay_q[i]);
        total  = bytes.size();
        nbeats = (total + 7) / 8;
        for (int k = 0; k < nbeats; k++) begin
            bt.data = '0;
            bt.be   = '0;
            for (int j = 0; j < 8; j++) begin
                if (8*k + j < total) begin
                    bt.data[8*j +: 8] = bytes[8*k + j];
                    bt.be[j] = 1'b1;
                end
            end
            bt.sop = (k == 0);
            bt.eop = (k == nbeats - 1);
            bt.len = total % 65536;
            exp_q.push_back(bt);
        end
    endtask

    task automatic fill_payload(input int n);
        pay_q.delete();
        for (int i = 0; i < n; i++) pay_q.push_back(8'($urandom));
    endtask

    // Entered just after a rising edge; returns just after the edge of the last accept.
    task automatic send_packet(input logic [47:0] a, input logic [31:0] b, input logic [15:0] c);
        int n;
        int nbeats;
        int tmo;
        bit acc;
        model_packet(a, b, c);
        iHeader_A = a;
        iHeader_B = b;
        iHeader_C = c;
        iHeader_valid = 1'b1;
        acc = 1'b0;
        tmo = 0;
        while (!acc) begin
            @(negedge iClk);
            acc = oHeader_ready;
            @(posedge iClk);
            #1;
            if (abort) begin
                iHeader_valid = 1'b0;
                return;
            end
            tmo++;
            if (!acc && tmo > 200) begin
                check("hdr_timeout", 64'd1, 64'd0);
                iHeader_valid = 1'b0;
                return;
            end
        end
        iHeader_valid = 1'b0;
        n = pay_q.size();
        nbeats = (n + 7) / 8;
        for (int k = 0; k < nbeats; k++) begin
            iPayload = '0;
            iPayload_byte_enable = '0;
            for (int j = 0; j < 8; j++) begin
                if (8*k + j < n) begin
                    iPayload[8*j +: 8] = pay_q[8*k + j];
                    iPayload_byte_enable[j] = 1'b1;
                end else begin
                    iPayload[8*j +: 8] = 8'($urandom);
                end
            end
            iPayload_eop = (k == nbeats - 1);
            iPayload_valid = 1'b1;
            acc = 1'b0;
            tmo = 0;
            while (!acc) begin
                @(negedge iClk);
                acc = oPayload_ready;
                @(posedge iClk);
                #1;
                if (abort) begin
                    iPayload_valid = 1'b0;
                    iPayload_eop = 1'b0;
                    return;
                end
                tmo++;
                if (!acc && tmo > 200) begin
                    check("pay_timeout", 64'd1, 64'd0);
                    iPayload_valid = 1'b0;
                    iPayload_eop = 1'b0;
                    return;
                end
            end
        end
        iPayload_valid = 1'b0;
        iPayload_eop = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int tmo;
        tmo = 0;
        while (exp_q.size() != 0 && tmo < 500) begin
            @(posedge iClk);
            tmo++;
        end
        check(tag, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        @(posedge iClk);
        #1;
    endtask

    always @(posedge iClk) begin
        #1;
        case (rdy_mode)
            0:       iReady = 1'b1;
            1:       iReady = ($urandom_range(0, 3) != 0);
            default: iReady = 1'b0;
        endcase
    end

    // Observe each beat on the falling edge; it transfers at the following rising edge.
    always @(negedge iClk) begin
        beat_t       e;
        logic [63:0] mask;
        cyc++;
        if (!iReset) begin
            hold_prev = 1'b0;
        end else begin
            check("rdy_excl", 64'(oHeader_ready & oPayload_ready), 64'd0);
            if (hold_prev) begin
                check("hold_valid", 64'(oValid), 64'd1);
                check("hold_data", oPacket, snap_data);
                check("hold_be", 64'(oByte_enable), 64'(snap_be));
                check("hold_sop", 64'(oSop), 64'(snap_sop));
                check("hold_eop", 64'(oEop), 64'(snap_eop));
            end
            if (oValid && !iReady) begin
                check("bp_hdr_ready", 64'(oHeader_ready), 64'd0);
                check("bp_pay_ready", 64'(oPayload_ready), 64'd0);
            end
            hold_prev = oValid && !iReady;
            snap_data = oPacket;
            snap_be   = oByte_enable;
            snap_sop  = oSop;
            snap_eop  = oEop;
            if (oValid && iReady) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    mask = '0;
                    for (int j = 0; j < 8; j++) mask[8*j +: 8] = {8{e.be[j]}};
                    check("beat_data", oPacket & mask, e.data & mask);
                    check("beat_be", 64'(oByte_enable), 64'(e.be));
                    check("beat_sop", 64'(oSop), 64'(e.sop));
                    check("beat_eop", 64'(oEop), 64'(e.eop));
`ifdef PACKET_BUILDER_LEN_EN
                    if (e.eop) check("length", 64'(oLength), 64'(e.len));
`endif
                    beats_seen++;
                    if (oSop) last_gap = cyc - eop_cyc;
                    if (oEop) eop_cyc = cyc;
                end
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, 64'(oValid), 64'd0);
        check({tag, "_sop"}, 64'(oSop), 64'd0);
        check({tag, "_eop"}, 64'(oEop), 64'd0);
        check({tag, "_be"}, 64'(oByte_enable), 64'd0);
        check({tag, "_packet"}, oPacket, 64'd0);
        check({tag, "_pay_ready"}, 64'(oPayload_ready), 64'd0);
        check({tag, "_hdr_ready"}, 64'(oHeader_ready), 64'd0);
`ifdef PACKET_BUILDER_LEN_EN
        check({tag, "_length"}, 64'(oLength), 64'd0);
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        iReset = 1'b0;
        iHeader_A = '0;
        iHeader_B = '0;
        iHeader_C = '0;
        iHeader_valid = 1'b0;
        iPayload = '0;
        iPayload_valid = 1'b0;
        iPayload_eop = 1'b0;
        iPayload_byte_enable = '0;
        repeat (3) @(posedge iClk);
        #2;
        check_all_zero("reset");
        @(negedge iClk);
        iReset = 1'b1;
        @(posedge iClk);
        #1;

        // 3-byte payload: two beats, 0xFF then 0x7F.
        base = beats_seen;
        fill_payload(3);
        send_packet(48'h0605_0403_0201, 32'h0A09_0807, 16'h0C0B);
        wait_drain("t3_drain");
        check("t3_beats", 64'(beats_seen - base), 64'd2);

        // Single full 8-byte beat: flush beat with 4 bytes.
        base = beats_seen;
        fill_payload(8);
        send_packet(48'(({$urandom, $urandom})), $urandom, 16'($urandom));
        wait_drain("t8_drain");
        check("t8_beats", 64'(beats_seen - base), 64'd3);

        // 25-byte payload over four input beats.
        base = beats_seen;
        fill_payload(25);
        send_packet(48'(({$urandom, $urandom})), $urandom, 16'($urandom));
        wait_drain("t25_drain");
        check("t25_beats", 64'(beats_seen - base), 64'd5);

        // Stall the second output beat for three cycles.
        base = beats_seen;
        fill_payload(16);
        fork
            send_packet(48'(({$urandom, $urandom})), $urandom, 16'($urandom));
            begin
                to = 0;
                while (beats_seen < base + 1 && to < 300) begin
                    @(posedge iClk);
                    to++;
                end
                rdy_mode = 2;
                @(negedge iClk);
                check("bp_beat_valid", 64'(oValid), 64'd1);
                check("bp_beat_sop", 64'(oSop), 64'd0);
                repeat (2) begin
                    @(negedge iClk);
                    check("bp_stall_pay_ready", 64'(oPayload_ready), 64'd0);
                    check("bp_stall_hdr_ready", 64'(oHeader_ready), 64'd0);
                end
                rdy_mode = 0;
            end
        join
        wait_drain("bp_drain");
        check("bp_beats", 64'(beats_seen - base), 64'd4);

        // Back-to-back packets: second sop directly after first eop.
        fill_payload(3);
        send_packet(48'(({$urandom, $urandom})), $urandom, 16'($urandom));
        fill_payload(10);
        send_packet(48'(({$urandom, $urandom})), $urandom, 16'($urandom));
        wait_drain("b2b_drain");
        check("b2b_gap", 64'(last_gap), 64'd1);

        // Reset in the middle of a packet.
        base = beats_seen;
        fill_payload(40);
        fork
            send_packet(48'(({$urandom, $urandom})), $urandom, 16'($urandom));
            begin
                to = 0;
                while (beats_seen < base + 2 && to < 300) begin
                    @(posedge iClk);
                    to++;
                end
                #3;
                abort = 1'b1;
                iReset = 1'b0;
                #1;
                check_all_zero("midrst");
            end
        join
        exp_q.delete();
        iHeader_valid = 1'b0;
        iPayload_valid = 1'b0;
        iPayload_eop = 1'b0;
        repeat (2) @(posedge iClk);
        @(negedge iClk);
        iReset = 1'b1;
        abort = 1'b0;
        @(posedge iClk);
        #1;
        base = beats_seen;
        fill_payload(9);
        send_packet(48'h1122_3344_5566, 32'h7788_99AA, 16'hBBCC);
        wait_drain("post_rst_drain");
        check("post_rst_beats", 64'(beats_seen - base), 64'd3);

        // Random lengths with random backpressure.
        rdy_mode = 1;
        for (int p = 0; p < 30; p++) begin
            fill_payload($urandom_range(1, 40));
            send_packet(48'(({$urandom, $urandom})), $urandom, 16'($urandom));
        end
        wait_drain("rand_drain");
        rdy_mode = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
